// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin sharing of one cacheline memory port (mem_*) between icache (i_*) and dcache (d_*), one line transaction at a time
module cache_mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);
  typedef enum logic [2:0] {IDLE, I_MEM, D_MEM, I_RESP, D_RESP} state_t;
  state_t state, state_n;
  logic last_d, last_d_n, rd_n, wr_n, grant_i, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [LINE_W-1:0] wdata_q, wdata_n, buf_q, buf_n;
  assign grant_d = (d_read || d_write) && (!i_read || !last_d);
  assign grant_i = i_read && !grant_d;
  assign i_resp = state == I_RESP;
  assign d_resp = state == D_RESP;
  assign i_rdata = buf_q;
  assign d_rdata = buf_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  always_comb begin
    state_n = state;
    last_d_n = last_d;
    addr_n = addr_q;
    wdata_n = wdata_q;
    buf_n = buf_q;
    rd_n = mem_read;
    wr_n = mem_write;
    case (state)
      IDLE: if (grant_i || grant_d) begin
        state_n = grant_d ? D_MEM : I_MEM;
        last_d_n = grant_d;
        addr_n = grant_d ? d_addr : i_addr;
        wdata_n = d_wdata;
        wr_n = grant_d && d_write;
        rd_n = !(grant_d && d_write);
      end
      I_MEM, D_MEM: if (mem_resp) begin
        state_n = state == D_MEM ? D_RESP : I_RESP;
        buf_n = mem_rdata;
        rd_n = 1'b0;
        wr_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last_d <= 1'b1;
      addr_q <= '0;
      wdata_q <= '0;
      buf_q <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      state <= state_n;
      last_d <= last_d_n;
      addr_q <= addr_n;
      wdata_q <= wdata_n;
      buf_q <= buf_n;
      mem_read <= rd_n;
      mem_write <= wr_n;
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: randomized transaction-level checks of cache_mem_arbiter against a request/grant reference model
module tb_cache_mem_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  logic clk = 1'b0, rst = 1'b0;
  logic i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, mem_resp = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0, d_addr = '0;
  logic [LINE_W-1:0] d_wdata = '0, mem_rdata = '0;
  logic i_resp, d_resp, mem_read, mem_write;
  logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  int checks = 0, errors = 0;
  bit grants[$];
  cache_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );
  always #5 clk = ~clk;
  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction
  task automatic do_reset;
    rst = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic test_reset;
    logic [LINE_W-1:0] p;
    logic [ADDR_W-1:0] a;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({i_resp, d_resp, mem_read, mem_write} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: resp=%b%b mem=%b%b addr=%0h", i_resp, d_resp, mem_read, mem_write, mem_addr);
    end
    rst = 1'b1;
    p = rand_line();
    d_write = 1'b1; d_addr = 32'h0000_1F00; d_wdata = p;
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b1) begin errors++; $display("FAIL reset_pre_write: mem_write=%b expected 1", mem_write); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL reset_abort: mem=%b%b expected 00", mem_read, mem_write); end
    @(negedge clk);
    d_write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({i_resp, d_resp, mem_read, mem_write} !== 4'b0) begin
        errors++; $display("FAIL reset_after: resp=%b%b mem=%b%b expected 0000", i_resp, d_resp, mem_read, mem_write);
      end
    end
    a = $urandom;
    i_read = 1'b1; i_addr = a;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== a) begin errors++; $display("FAIL reset_idle: mem_read=%b addr=%0h expected 1 %0h", mem_read, mem_addr, a); end
  endtask
  task automatic test_lone_read;
    logic [LINE_W-1:0] line = {32{8'hA5}};
    do_reset();
    i_read = 1'b1; i_addr = 32'h0000_0060;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (mem_read !== (k <= 5) || mem_write !== 1'b0 || (k <= 5 && mem_addr !== 32'h60)) begin
        errors++; $display("FAIL lone_mem c%0d: rd=%b wr=%b addr=%0h", k, mem_read, mem_write, mem_addr);
      end
      checks++;
      if (i_resp !== (k == 6) || d_resp !== 1'b0 || (k == 6 && i_rdata !== line)) begin
        errors++; $display("FAIL lone_resp c%0d: i_resp=%b d_resp=%b rdata=%0h", k, i_resp, d_resp, i_rdata);
      end
      mem_resp = (k == 5);
      mem_rdata = (k == 5) ? line : rand_line();
      if (k == 6) i_read = 1'b0;
    end
  endtask
  task automatic test_write_back;
    logic [LINE_W-1:0] p = rand_line();
    int n = $urandom_range(1, 4);
    do_reset();
    d_write = 1'b1; d_addr = 32'h0000_1F00; d_wdata = p;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      checks++;
      if (mem_write !== (k <= n) || mem_read !== 1'b0 || (k <= n && (mem_wdata !== p || mem_addr !== 32'h1F00))) begin
        errors++; $display("FAIL wb_mem c%0d: rd=%b wr=%b addr=%0h wdata=%0h expected %0h", k, mem_read, mem_write, mem_addr, mem_wdata, p);
      end
      checks++;
      if (d_resp !== (k == n + 1) || i_resp !== 1'b0) begin
        errors++; $display("FAIL wb_resp c%0d: d_resp=%b i_resp=%b", k, d_resp, i_resp);
      end
      mem_resp = (k == n);
      if (k == n + 1) d_write = 1'b0;
    end
  endtask
  task automatic test_stray;
    logic [ADDR_W-1:0] a = $urandom;
    do_reset();
    mem_resp = 1'b1; mem_rdata = rand_line();
    @(negedge clk);
    mem_resp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({i_resp, d_resp, mem_read, mem_write} !== 4'b0) begin
        errors++; $display("FAIL stray: resp=%b%b mem=%b%b expected 0000", i_resp, d_resp, mem_read, mem_write);
      end
    end
    d_read = 1'b1; d_addr = a;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== a) begin errors++; $display("FAIL stray_idle: mem_read=%b addr=%0h expected 1 %0h", mem_read, mem_addr, a); end
  endtask
  // mode 0: random traffic with stray mem_resp, 1: both sides always requesting reads, 2: dcache only
  task automatic traffic(input int n, input int mode, input string name);
    bit iw = 0, dw = 0, dop = 0, was_idle = 1, in_txn = 0, txn_d = 0, txn_w = 0, mr = 0, resp_last = 0, last_d = 1;
    bit started, resp_now, exp_mem, idle_now;
    logic [ADDR_W-1:0] ia = '0, da = '0, exp_a = '0;
    logic [LINE_W-1:0] dwd = '0, exp_wd = '0, exp_rd = '0;
    int cnt = 0, done = 0, issued = 0, cyc = 0;
    do_reset();
    grants.delete();
    while (done < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      started = was_idle && (iw || dw);
      resp_now = in_txn && mr;
      checks++;
      if (i_resp !== (resp_now && !txn_d) || d_resp !== (resp_now && txn_d)) begin
        errors++; $display("FAIL %s resp c%0d: i_resp=%b d_resp=%b expected %b %b", name, cyc, i_resp, d_resp, resp_now && !txn_d, resp_now && txn_d);
      end
      if (resp_now && !txn_w) begin
        checks++;
        if ((txn_d ? d_rdata : i_rdata) !== exp_rd) begin
          errors++; $display("FAIL %s rdata c%0d: got %0h expected %0h", name, cyc, txn_d ? d_rdata : i_rdata, exp_rd);
        end
      end
      if (started) begin
        txn_d = dw && (!iw || !last_d);
        txn_w = txn_d && dop;
        exp_a = txn_d ? da : ia;
        exp_wd = dwd;
        last_d = txn_d;
        grants.push_back(txn_d);
        cnt = $urandom_range(0, 3);
        in_txn = 1;
      end
      exp_mem = in_txn && !resp_now;
      checks++;
      if ({mem_read, mem_write} !== (exp_mem ? {!txn_w, txn_w} : 2'b00)) begin
        errors++; $display("FAIL %s mem_op c%0d: rd=%b wr=%b expected active=%b write=%b", name, cyc, mem_read, mem_write, exp_mem, txn_w);
      end
      if (exp_mem) begin
        checks++;
        if (mem_addr !== exp_a || (txn_w && mem_wdata !== exp_wd)) begin
          errors++; $display("FAIL %s mem_payload c%0d: addr=%0h expected %0h", name, cyc, mem_addr, exp_a);
        end
      end
      if (resp_now) begin
        in_txn = 0;
        done++;
        if (txn_d) dw = 0; else iw = 0;
      end
      idle_now = (was_idle && !started) || resp_last;
      resp_last = resp_now;
      was_idle = idle_now;
      if (!iw && !(resp_now && !txn_d) && issued < n && mode != 2 && (mode == 1 || $urandom_range(0, 2) == 0)) begin
        iw = 1; ia = $urandom; issued++;
      end
      if (!dw && !(resp_now && txn_d) && issued < n && (mode != 0 || $urandom_range(0, 2) == 0)) begin
        dw = 1; da = $urandom; dwd = rand_line(); dop = (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1)); issued++;
      end
      i_read = iw; i_addr = ia;
      d_read = dw && !dop; d_write = dw && dop; d_addr = da; d_wdata = dwd;
      if (in_txn) begin
        mr = (cnt == 0);
        if (cnt > 0) cnt--;
      end else mr = (mode == 0) && ($urandom_range(0, 4) == 0);
      mem_resp = mr;
      mem_rdata = rand_line();
      if (mr) exp_rd = mem_rdata;
    end
    checks++;
    if (done != n) begin errors++; $display("FAIL %s timeout: %0d of %0d transactions completed", name, done, n); end
    i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
  endtask
  task automatic test_simultaneous;
    traffic(2, 1, "simul");
    checks++;
    if (grants.size() != 2 || grants[0] != 1'b0 || grants[1] != 1'b1) begin
      errors++; $display("FAIL simul_order: %0d grants, first=%b expected I then D", grants.size(), grants.size() > 0 ? grants[0] : 1'b1);
    end
  endtask
  task automatic test_fairness;
    traffic(6, 1, "fair");
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= grants.size() || grants[k] != 1'(k % 2)) begin
        errors++; $display("FAIL fair_order g%0d: got %b expected %b", k, k < grants.size() ? grants[k] : 1'bx, 1'(k % 2));
      end
    end
  endtask
  task automatic test_back_to_back;
    traffic(4, 2, "b2b");
  endtask
  task automatic test_random;
    traffic(40, 0, "rand");
  endtask
  initial begin
    test_reset();
    test_lone_read();
    test_write_back();
    test_stray();
    test_simultaneous();
    test_fairness();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
